// File: rtl/bird_pkg.sv
// Shared definitions for the bird motion stage.
//   state_e : game FSM encoding (ST_INITIAL / ST_FLIGHT / ST_STOP)
//   Geometry and physics constants for the bird and the visible screen.
package bird_pkg;

    typedef enum logic [1:0] {
        ST_INITIAL = 2'd0,
        ST_FLIGHT  = 2'd1,
        ST_STOP    = 2'd2
    } state_e;

    localparam int unsigned BIRD_X   = 100;
    localparam int unsigned BIRD_W   = 20;
    localparam int unsigned BIRD_H   = 20;
    localparam int unsigned Y_START  = 230;
    localparam int unsigned SCREEN_H = 480;
    localparam int unsigned Y_MAX    = SCREEN_H - BIRD_H;

    localparam int GRAVITY  = 1;
    localparam int FLAP_VEL = 8;
    localparam int MAX_FALL = 10;
    localparam int VEL_W    = 6;

endpackage

// File: rtl/flap_edge_detect.sv
// Flap input conditioner, only present when FLAP_EDGE_EN is defined.
// Two-flop synchroniser on the raw Flap level followed by a rising-edge
// detector, so one button press produces exactly one flap pulse.
//   clk_i  : system clock
//   rst_i  : synchronous active-high reset
//   flap_i : raw asynchronous flap level
//   rise_o : one-cycle pulse on each synchronised rising edge
`ifdef FLAP_EDGE_EN
module flap_edge_detect (
    input  logic clk_i,
    input  logic rst_i,
    input  logic flap_i,
    output logic rise_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= flap_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rise_o = sync2_q & ~prev_q;

endmodule
`endif

// File: rtl/bird_physics.sv
// Bird motion stage: owns the bird bounding box, integrates gravity and flap
// impulses once per frame Tick and runs the INITIAL/FLIGHT/STOP game FSM.
// Optional macro FLAP_EDGE_EN: Flap is a raw level, synchronised and
// edge-detected internally; otherwise Flap must be a clean one-cycle pulse.
//   Clk, reset (sync, active-high), Tick (frame enable)
//   Start / Ack / Stop (levels), Flap (pulse or level, see above)
//   Bird_X_L/Bird_X_R/Bird_Y_T/Bird_Y_B : box edges (10 bit)
//   Hit_Floor : in STOP because of floor contact
//   q_Initial/q_Flight/q_Stop : one-hot game state
module bird_physics
    import bird_pkg::*;
(
    input  logic       Clk,
    input  logic       reset,
    input  logic       Tick,
    input  logic       Start,
    input  logic       Ack,
    input  logic       Stop,
    input  logic       Flap,
    output logic [9:0] Bird_X_L,
    output logic [9:0] Bird_X_R,
    output logic [9:0] Bird_Y_T,
    output logic [9:0] Bird_Y_B,
    output logic       Hit_Floor,
    output logic       q_Initial,
    output logic       q_Flight,
    output logic       q_Stop
);

    localparam logic signed [VEL_W-1:0] VEL_FLAP = VEL_W'(-FLAP_VEL);
    localparam logic signed [VEL_W-1:0] VEL_MAX  = VEL_W'(MAX_FALL);
    localparam logic signed [VEL_W-1:0] VEL_GRAV = VEL_W'(GRAVITY);
    localparam logic signed [10:0]      Y_MAX_S  = 11'(Y_MAX);

    state_e                  state_q, state_d;
    logic [9:0]              y_q, y_d;
    logic signed [VEL_W-1:0] vel_q, vel_d;
    logic                    hit_q, hit_d;
    logic                    armed_q, armed_d;
    logic                    pend_q, pend_d;

    logic                    flap_req;
    logic signed [VEL_W-1:0] vel_n;
    logic signed [10:0]      y_n;

`ifdef FLAP_EDGE_EN
    flap_edge_detect u_flap_edge (
        .clk_i  (Clk),
        .rst_i  (reset),
        .flap_i (Flap),
        .rise_o (flap_req)
    );
`else
    assign flap_req = Flap;
`endif

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        vel_d   = vel_q;
        hit_d   = hit_q;
        armed_d = armed_q;
        pend_d  = pend_q;
        vel_n   = '0;
        y_n     = '0;

        case (state_q)
            ST_INITIAL: begin
                pend_d  = 1'b0;
                // Start must be seen low before it can launch, so a shared
                // Start/Ack button cannot fall straight through INITIAL.
                armed_d = armed_q | ~Start;
                if (Start && armed_q) begin
                    state_d = ST_FLIGHT;
                end
            end

            ST_FLIGHT: begin
                if (Stop) begin
                    // Collision wins: this cycle's Tick update is dropped.
                    state_d = ST_STOP;
                end else if (Tick) begin
                    pend_d = 1'b0;
                    if (flap_req || pend_q) begin
                        vel_n = VEL_FLAP;
                    end else if (vel_q >= VEL_MAX) begin
                        vel_n = VEL_MAX;
                    end else begin
                        vel_n = vel_q + VEL_GRAV;
                    end
                    y_n = $signed({1'b0, y_q})
                        + $signed({{(11 - VEL_W){vel_n[VEL_W-1]}}, vel_n});
                    if (y_n[10]) begin
                        y_d   = '0;
                        vel_d = '0;
                    end else if (y_n >= Y_MAX_S) begin
                        y_d     = 10'(Y_MAX);
                        vel_d   = '0;
                        hit_d   = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        y_d   = y_n[9:0];
                        vel_d = vel_n;
                    end
                end else begin
                    // Hold a flap that arrives between frame ticks.
                    pend_d = pend_q | flap_req;
                end
            end

            ST_STOP: begin
                if (Ack) begin
                    state_d = ST_INITIAL;
                    y_d     = 10'(Y_START);
                    vel_d   = '0;
                    hit_d   = 1'b0;
                    armed_d = 1'b0;
                    pend_d  = 1'b0;
                end
            end

            default: state_d = ST_INITIAL;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q <= ST_INITIAL;
            y_q     <= 10'(Y_START);
            vel_q   <= '0;
            hit_q   <= 1'b0;
            armed_q <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            vel_q   <= vel_d;
            hit_q   <= hit_d;
            armed_q <= armed_d;
            pend_q  <= pend_d;
        end
    end

    assign Bird_X_L  = 10'(BIRD_X);
    assign Bird_X_R  = 10'(BIRD_X + BIRD_W - 1);
    assign Bird_Y_T  = y_q;
    assign Bird_Y_B  = y_q + 10'(BIRD_H - 1);
    assign Hit_Floor = hit_q;
    assign q_Initial = (state_q == ST_INITIAL);
    assign q_Flight  = (state_q == ST_FLIGHT);
    assign q_Stop    = (state_q == ST_STOP);

endmodule
